seg7_scan_driver: RTL and testbench

//  - Time-multiplexed driver for an N-digit common-anode 7-segment display. Successor to the single-digit BCD decoder.
//  - Scans digits with a programmable refresh divider and anti-ghosting dead time.
//  - Adds per-digit decimal point, blanking and blinking. Sits between counter/stopwatch logic and board pins.

---
 rtl/seg7_scan_driver.sv | 74 +++++++
 tb/tb_seg7_scan_driver.sv | 89 ++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit common-anode 7-segment driver with dead time, blank and blink.
// Define SEG7_HEX_EN to decode codes 10-15 as A,b,C,d,E,F; otherwise those codes leave segments off.
module seg7_scan_driver #(
   parameter int NUM_DIGITS  = 4,
   parameter int SCAN_DIV    = 100000,
   parameter int DEAD_CYCLES = 1000,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [7:0]              seg,
   output logic [NUM_DIGITS-1:0]   an
);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [SW-1:0] DEAD       = SW'(DEAD_CYCLES);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
   logic [SW-1:0] scan_cnt;
   logic [IW-1:0] idx;
   logic [BW-1:0] blink_cnt;
   logic          blink_ph;
   logic [3:0]    code;
   logic [6:0]    dec;
   logic          dark;
   always_comb begin
      code = 4'(digits >> {idx, 2'b00});
      dark = blank_mask[idx] | (blink_mask[idx] & blink_ph) | (scan_cnt < DEAD);
      case (code)
         4'h0: dec = 7'h40;
         4'h1: dec = 7'h79;
         4'h2: dec = 7'h24;
         4'h3: dec = 7'h30;
         4'h4: dec = 7'h19;
         4'h5: dec = 7'h12;
         4'h6: dec = 7'h02;
         4'h7: dec = 7'h78;
         4'h8: dec = 7'h00;
         4'h9: dec = 7'h10;
`ifdef SEG7_HEX_EN
         4'hA: dec = 7'h08;
         4'hB: dec = 7'h03;
         4'hC: dec = 7'h46;
         4'hD: dec = 7'h21;
         4'hE: dec = 7'h06;
         4'hF: dec = 7'h0E;
`endif
         default: dec = 7'h7F;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scan_cnt  <= '0;
         idx       <= '0;
         blink_cnt <= '0;
         blink_ph  <= 1'b0;
         seg       <= 8'hFF;
         an        <= '1;
      end else begin
         scan_cnt  <= scan_cnt == SCAN_LAST ? '0 : scan_cnt + 1'b1;
         if (scan_cnt == SCAN_LAST) idx <= idx == IDX_LAST ? '0 : idx + 1'b1;
         blink_cnt <= blink_cnt == BLINK_LAST ? '0 : blink_cnt + 1'b1;
         if (blink_cnt == BLINK_LAST) blink_ph <= ~blink_ph;
         seg       <= dark ? 8'hFF : {~dp[idx], dec};
         an        <= dark ? '1 : ~(NUM_DIGITS'(1) << idx);
      end
   end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed scan, dp, blank, blink, hex decode and mid-slot reset checks.
module tb_seg7_scan_driver;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] digits = 16'h1234;
   logic [3:0]  dp = 4'b0000;
   logic [3:0]  blank_mask = 4'b0000;
   logic [3:0]  blink_mask = 4'b0000;
   logic [7:0]  seg;
   logic [3:0]  an;
   int          n_assert = 0;
   int          n_fail = 0;
`ifdef SEG7_HEX_EN
   localparam logic [7:0] SEG_A = 8'h88;
`else
   localparam logic [7:0] SEG_A = 8'hFF;
`endif
   seg7_scan_driver #(
      .NUM_DIGITS(4), .SCAN_DIV(4), .DEAD_CYCLES(1), .BLINK_DIV(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .digits(digits), .dp(dp),
      .blank_mask(blank_mask), .blink_mask(blink_mask), .seg(seg), .an(an)
   );
   always #5 clk = ~clk;
   task automatic tick_chk(input string tag, input logic [3:0] ae, input logic [7:0] se);
      @(posedge clk);
      #1;
      n_assert++;
      assert (an === ae && seg === se) else begin
         n_fail++;
         $error("FAIL %s: an=%b seg=%h, expected an=%b seg=%h", tag, an, seg, ae, se);
      end
   endtask
   task automatic slot_chk(input string tag, input logic [3:0] ae, input logic [7:0] se);
      tick_chk({tag, "_dead"}, 4'hF, 8'hFF);
      for (int i = 0; i < 3; i++) tick_chk(tag, ae, se);
   endtask
   task automatic dark_slot(input string tag);
      for (int i = 0; i < 4; i++) tick_chk(tag, 4'hF, 8'hFF);
   endtask
   initial begin
      tick_chk("rst1", 4'hF, 8'hFF);
      tick_chk("rst2", 4'hF, 8'hFF);
      tick_chk("rst3", 4'hF, 8'hFF);
      rst_n = 1'b1;
      slot_chk("d0", 4'b1110, 8'h99);
      slot_chk("d1", 4'b1101, 8'hB0);
      slot_chk("d2", 4'b1011, 8'hA4);
      slot_chk("d3", 4'b0111, 8'hF9);
      dp = 4'b0010;
      slot_chk("dp_d0", 4'b1110, 8'h99);
      slot_chk("dp_d1", 4'b1101, 8'h30);
      slot_chk("dp_d2", 4'b1011, 8'hA4);
      slot_chk("dp_d3", 4'b0111, 8'hF9);
      dp = 4'b0000;
      blank_mask = 4'b0100;
      slot_chk("bl_d0", 4'b1110, 8'h99);
      slot_chk("bl_d1", 4'b1101, 8'hB0);
      dark_slot("bl_d2");
      slot_chk("bl_d3", 4'b0111, 8'hF9);
      blank_mask = 4'b0000;
      blink_mask = 4'b0001;
      dark_slot("bk_d0_off");
      slot_chk("bk_d1", 4'b1101, 8'hB0);
      slot_chk("bk_d2", 4'b1011, 8'hA4);
      slot_chk("bk_d3", 4'b0111, 8'hF9);
      slot_chk("bk_d0_on", 4'b1110, 8'h99);
      slot_chk("bk_d1b", 4'b1101, 8'hB0);
      slot_chk("bk_d2b", 4'b1011, 8'hA4);
      slot_chk("bk_d3b", 4'b0111, 8'hF9);
      dark_slot("bk_d0_off2");
      blink_mask = 4'b0000;
      digits = 16'h000A;
      slot_chk("hx_d1", 4'b1101, 8'hC0);
      slot_chk("hx_d2", 4'b1011, 8'hC0);
      slot_chk("hx_d3", 4'b0111, 8'hC0);
      slot_chk("hx_d0", 4'b1110, SEG_A);
      slot_chk("hx_d1b", 4'b1101, 8'hC0);
      tick_chk("mid_dead", 4'hF, 8'hFF);
      tick_chk("mid_lit", 4'b1011, 8'hC0);
      rst_n = 1'b0;
      tick_chk("mid_rst", 4'hF, 8'hFF);
      rst_n = 1'b1;
      slot_chk("rs_d0", 4'b1110, SEG_A);
      slot_chk("rs_d1", 4'b1101, 8'hC0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
